htd_arb: RTL
============

# htd_arb

Round-robin arbiter that shares one `htd_opt` conversion datapath between `REQ_NUM` requesters. It accepts words from requesters over valid/ready, issues them one per cycle as `htd_opt` write strobes, and records each issuer's ID in an in-order tag FIFO. It steers each `htd_opt` result back to the requester that issued the word. It sits between client logic and a single `htd_opt` instance and makes no assumption about `htd_opt` latency.

## Interface
- DATA_WIDTH, 8, width of a request word; `htd_opt` result is DATA_WIDTH+1
- REQ_NUM, 4, number of requesters (2..8)
- TAG_DEPTH, 8, maximum words in flight inside `htd_opt` (power of 2, ≥2)

- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- iv_req_data  in  REQ_NUM*DATA_WIDTH  request words; requester k uses bits [k*DATA_WIDTH +: DATA_WIDTH]
- iv_req_valid  in  REQ_NUM  per-requester valid
- ov_req_ready  out  REQ_NUM  per-requester ready, one-hot or zero
- ov_htd_data  out  DATA_WIDTH  word to `htd_opt` iv_data
- o_htd_wr  out  1  strobe to `htd_opt` i_data_wr
- iv_htd_data  in  DATA_WIDTH+1  result from `htd_opt` ov_data
- i_htd_wr  in  1  result strobe from `htd_opt` o_data_wr
- ov_rsp_data  out  DATA_WIDTH+1  result returned to a requester
- ov_rsp_wr  out  REQ_NUM  one-hot strobe marking the owning requester
- ov_tag_cnt  out  $clog2(TAG_DEPTH)+1  words currently in flight
- o_err  out  1  sticky flag: a result arrived with an empty tag FIFO

## Operation
- **Handshake:** a transfer happens on a cycle where `iv_req_valid[k]` & `ov_req_ready[k]`. At most one transfer per cycle.
- **Grant:** combinational. Among valid requesters, pick the first at or after round-robin pointer `rr_ptr`, wrapping from REQ_NUM-1 to 0. Grant is suppressed entirely when `ov_tag_cnt == TAG_DEPTH`. `ov_req_ready` equals the grant vector.
- **Pointer update:** after a transfer from k, `rr_ptr` becomes (k+1) mod REQ_NUM. With no transfer, `rr_ptr` holds.
- **On a transfer:**
  - the word is registered into `ov_htd_data` and `o_htd_wr` is asserted for the next cycle;
  - ID k is pushed into the tag FIFO at the same clock edge.
- **On `i_htd_wr`:**
  - pop the head tag t;
  - register `iv_htd_data` into `ov_rsp_data` and assert `ov_rsp_wr[t]` for one cycle.
- **Simultaneous push and pop:** both are performed and `ov_tag_cnt` is unchanged.
- **Full:** full is evaluated on the registered count. A pop in the same cycle does not re-open ready in that cycle.
- **Pop with empty FIFO:** the result is dropped, `ov_rsp_wr` stays 0, and `o_err` is set. `o_err` clears only on reset.
- **Hold requirement:** requesters must keep valid and data stable until ready. The block does not buffer request words.

## Timing
- **Reset values:** `ov_req_ready` = 0 while reset is asserted. All registers clear: `ov_htd_data`=0, `o_htd_wr`=0, `ov_rsp_data`=0, `ov_rsp_wr`=0, `ov_tag_cnt`=0, `o_err`=0, `rr_ptr`=0, tag FIFO empty.
- **Request latency:** handshake in cycle N → `o_htd_wr`=1 in cycle N+1.
- **Result latency:** `i_htd_wr` in cycle M → `ov_rsp_wr`=1 in cycle M+1.
- **Throughput:** back-to-back transfers give one issue per cycle.
- **Reset mid-operation:** in-flight tags are discarded. Results arriving after reset deassertion with an empty FIFO set `o_err`.

## Configuration
- **Macro `HTD_ARB_STAT_EN`:**
  - Defined: adds output port `ov_stall_cnt` [15:0]. It increments on every cycle where `iv_req_valid` is non-zero and no transfer occurs, saturates at 16'hFFFF, and resets to 0.
  - Undefined: the port and its counter are absent. All other behaviour is identical.

## Test plan
- **Single requester:** reset, then requester 0 presents 8'h05 for one handshake → `o_htd_wr` high for one cycle with `ov_htd_data`=8'h05 in the next cycle. A model result 9'h005 on `i_htd_wr` → `ov_rsp_wr`=4'b0001 with `ov_rsp_data`=9'h005 one cycle later.
- **Fairness:** all four requesters hold valid with data 8'h10..8'h13 → grants in order 0,1,2,3,0,… and `o_htd_wr` high every cycle. Returned results carry the matching one-hot strobes in issue order.
- **Full:** the `htd_opt` model withholds results while 8 words are issued → `ov_tag_cnt`=8 and `ov_req_ready`=0. Releasing one result → ready reasserts the cycle after `ov_tag_cnt` drops to 7.
- **Simultaneous push/pop:** with `ov_tag_cnt`=3, a transfer and `i_htd_wr` occur in the same cycle → `ov_tag_cnt` stays 3 and the response goes to the oldest tag.
- **Error:** `i_htd_wr` asserted with an empty FIFO → `ov_rsp_wr`=0 and `o_err`=1, staying 1 until `i_rst_n` is pulsed low.
- **`HTD_ARB_STAT_EN`:** build with the macro defined and the FIFO full; hold requester 2 valid for 5 cycles → `ov_stall_cnt`=5.

Source files
------------

// File: rtl/htd_arb.sv
// htd_arb -- round-robin front end that shares one htd_opt conversion
// datapath between REQ_NUM requesters.
//
// Accepted words go out as htd_opt write strobes, one per cycle. The ID of
// each issuer is pushed into an in-order tag FIFO. Each htd_opt result pops
// the oldest tag and is steered back to that requester. No htd_opt latency
// is assumed.
//
// Ports:
//   i_clk, i_rst_n  clock (rising edge), asynchronous active-low reset
//   iv_req_data     REQ_NUM packed request words (requester k at k*DATA_WIDTH)
//   iv_req_valid    per-requester valid
//   ov_req_ready    combinational grant, one-hot or zero
//   ov_htd_data     registered word to htd_opt iv_data
//   o_htd_wr        registered strobe to htd_opt i_data_wr
//   iv_htd_data     result from htd_opt ov_data
//   i_htd_wr        result strobe from htd_opt o_data_wr
//   ov_rsp_data     registered result returned to a requester
//   ov_rsp_wr       registered one-hot strobe marking the owning requester
//   ov_tag_cnt      words currently in flight
//   o_err           sticky: a result arrived while no tag was outstanding
//   ov_stall_cnt    (only with HTD_ARB_STAT_EN) saturating count of cycles
//                   in which some requester was valid but nothing transferred
//
// Optional feature macro: HTD_ARB_STAT_EN
module htd_arb #(
   parameter int DATA_WIDTH = 8,
   parameter int REQ_NUM    = 4,
   parameter int TAG_DEPTH  = 8
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic [REQ_NUM*DATA_WIDTH-1:0] iv_req_data,
   input  logic [REQ_NUM-1:0]            iv_req_valid,
   output logic [REQ_NUM-1:0]            ov_req_ready,
   output logic [DATA_WIDTH-1:0]         ov_htd_data,
   output logic                          o_htd_wr,
   input  logic [DATA_WIDTH:0]           iv_htd_data,
   input  logic                          i_htd_wr,
   output logic [DATA_WIDTH:0]           ov_rsp_data,
   output logic [REQ_NUM-1:0]            ov_rsp_wr,
   output logic [$clog2(TAG_DEPTH):0]    ov_tag_cnt,
   output logic                          o_err
`ifdef HTD_ARB_STAT_EN
   ,
   output logic [15:0]                   ov_stall_cnt
`endif
);

   localparam int PW = $clog2(REQ_NUM);
   localparam int AW = $clog2(TAG_DEPTH);
   localparam int CW = AW + 1;

   logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
   logic [PW-1:0]         tag_mem_q [TAG_DEPTH];
   logic [PW-1:0]         tag_mem_d [TAG_DEPTH];
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         tag_cnt_q, tag_cnt_d;
   logic [DATA_WIDTH-1:0] htd_data_q, htd_data_d;
   logic                  htd_wr_q, htd_wr_d;
   logic [DATA_WIDTH:0]   rsp_data_q, rsp_data_d;
   logic [REQ_NUM-1:0]    rsp_wr_q, rsp_wr_d;
   logic                  err_q, err_d;

   logic [REQ_NUM-1:0]    grant_s;
   logic [PW-1:0]         gnt_idx_s;
   logic [PW:0]           idx_s;
   logic                  found_s;
   logic                  full_s;
   logic                  push_s;
   logic                  pop_s;

   // Round-robin grant: first valid requester at or after rr_ptr, wrapping.
   // Full is judged on the registered count, so a same-cycle pop does not
   // re-open ready. Ready is forced low while reset is held.
   always_comb begin
      grant_s   = '0;
      gnt_idx_s = '0;
      found_s   = 1'b0;
      idx_s     = '0;
      full_s    = (tag_cnt_q == CW'(TAG_DEPTH));
      for (int i = 0; i < REQ_NUM; i++) begin
         idx_s = {1'b0, rr_ptr_q} + (PW+1)'(i);
         if (idx_s >= (PW+1)'(REQ_NUM)) begin
            idx_s = idx_s - (PW+1)'(REQ_NUM);
         end else begin
            idx_s = idx_s;
         end
         if (!found_s && !full_s && i_rst_n && iv_req_valid[idx_s[PW-1:0]]) begin
            found_s                  = 1'b1;
            grant_s[idx_s[PW-1:0]]   = 1'b1;
            gnt_idx_s                = idx_s[PW-1:0];
         end else begin
            found_s = found_s;
         end
      end
   end

   assign ov_req_ready = grant_s;
   assign push_s       = found_s;
   // A result with no outstanding tag is dropped and flagged instead.
   assign pop_s        = i_htd_wr & (tag_cnt_q != CW'(0));

   // Next-state for issue path, tag FIFO, response path and error flag.
   always_comb begin
      tag_mem_d  = tag_mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      rr_ptr_d   = rr_ptr_q;
      htd_data_d = htd_data_q;
      htd_wr_d   = push_s;
      rsp_data_d = rsp_data_q;
      rsp_wr_d   = '0;
      err_d      = err_q | (i_htd_wr & (tag_cnt_q == CW'(0)));

      if (push_s) begin
         htd_data_d          = iv_req_data[gnt_idx_s*DATA_WIDTH +: DATA_WIDTH];
         tag_mem_d[wr_ptr_q] = gnt_idx_s;
         wr_ptr_d            = wr_ptr_q + AW'(1);
         rr_ptr_d            = (gnt_idx_s == PW'(REQ_NUM - 1)) ? PW'(0) : gnt_idx_s + PW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
         rsp_data_d                    = iv_htd_data;
         rsp_wr_d[tag_mem_q[rd_ptr_q]] = 1'b1;
         rd_ptr_d                      = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      case ({push_s, pop_s})
         2'b10:   tag_cnt_d = tag_cnt_q + CW'(1);
         2'b01:   tag_cnt_d = tag_cnt_q - CW'(1);
         default: tag_cnt_d = tag_cnt_q;
      endcase
   end

   // State registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rr_ptr_q   <= '0;
         tag_mem_q  <= '{default: '0};
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         tag_cnt_q  <= '0;
         htd_data_q <= '0;
         htd_wr_q   <= 1'b0;
         rsp_data_q <= '0;
         rsp_wr_q   <= '0;
         err_q      <= 1'b0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         tag_mem_q  <= tag_mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         tag_cnt_q  <= tag_cnt_d;
         htd_data_q <= htd_data_d;
         htd_wr_q   <= htd_wr_d;
         rsp_data_q <= rsp_data_d;
         rsp_wr_q   <= rsp_wr_d;
         err_q      <= err_d;
      end
   end

   assign ov_htd_data = htd_data_q;
   assign o_htd_wr    = htd_wr_q;
   assign ov_rsp_data = rsp_data_q;
   assign ov_rsp_wr   = rsp_wr_q;
   assign ov_tag_cnt  = tag_cnt_q;
   assign o_err       = err_q;

`ifdef HTD_ARB_STAT_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;

   // Stall counter: valid present but no transfer, saturating.
   always_comb begin
      if ((iv_req_valid != '0) && !push_s && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // Stall counter register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         stall_cnt_q <= 16'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign ov_stall_cnt = stall_cnt_q;
`endif

endmodule
